// File: rtl/display_arbiter_if.sv
// Display arbiter bus: source requests and values in, display value and owner out.
//
// Request/grant semantics: req[i] is a level held by source i for as long as it
// wants the display. grant is one-hot (or zero when idle) and changes on the same
// edge that disp_val switches to the new owner's value. A source sees its grant
// bit drop either on its own release or when the dwell time expires while
// another source is waiting.
interface display_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req;
   logic [32*NREQ-1:0]   vals;
   logic [31:0]          disp_val;
   logic [NREQ-1:0]      grant;
   logic [2:0]           owner;
   logic                 busy;
   logic                 state_dbg;

   // Sources drive requests and values, the arbiter drives the display side
   modport master (
      output req, vals,
      input  disp_val, grant, owner, busy, state_dbg
   );

   modport slave (
      input  req, vals,
      output disp_val, grant, owner, busy, state_dbg
   );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit display among NREQ sources, with a
// minimum dwell time so a contested owner's value stays readable.
module display_arbiter #(
   parameter int          NREQ     = 4,
   parameter logic [31:0] DWELL    = 32'd50000000,
   parameter logic [31:0] IDLE_VAL = 32'h0000_0000
) (
   input logic              clk,
   input logic              resetn,
   display_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       state,     state_nxt;
   logic [2:0]       owner,     owner_nxt;
   logic [2:0]       last,      last_nxt;
   logic [31:0]      dwell_cnt, dwell_nxt;
   logic [31:0]      disp_val,  disp_nxt;

   logic [NREQ-1:0]  own_onehot;
   logic [NREQ-1:0]  other_req;
   logic             own_req;
   logic [2:0]       pick_all;
   logic [2:0]       pick_oth;

   // First requester after 'from' in circular order; 'from' itself is checked last
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] from);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(from) + k) % NREQ;
         if (!found && r[idx[IW-1:0]]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Select one source's 32-bit value from the packed bus
   function automatic logic [31:0] val_of(input logic [32*NREQ-1:0] v, input logic [2:0] idx);
      logic [31:0] res;
      res = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (idx == 3'(i)) res = v[32*i +: 32];
      end
      return res;
   endfunction

   // Decode current owner and find RR winners over all and over contenders only
   always_comb begin
      own_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner;
      own_req    = |(bus.req & own_onehot);
      other_req  = bus.req & ~own_onehot;
      pick_all   = rr_pick(bus.req, last);
      pick_oth   = rr_pick(other_req, last);
   end

   // Next-state logic: grant, early release, dwell-expiry preemption, hold
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      dwell_nxt = dwell_cnt;
      disp_nxt  = disp_val;
      case (state)
         ST_IDLE: begin
            disp_nxt = IDLE_VAL;
            if (|bus.req) begin
               state_nxt = ST_HOLD;
               owner_nxt = pick_all;
               last_nxt  = pick_all;
               dwell_nxt = DWELL - 32'd1;
               disp_nxt  = val_of(bus.vals, pick_all);
            end
         end
         default: begin
            if (!own_req) begin
               // Owner let go: hand over immediately or fall back to idle
               if (|other_req) begin
                  owner_nxt = pick_oth;
                  last_nxt  = pick_oth;
                  dwell_nxt = DWELL - 32'd1;
                  disp_nxt  = val_of(bus.vals, pick_oth);
               end else begin
                  state_nxt = ST_IDLE;
                  owner_nxt = 3'd0;
                  dwell_nxt = 32'd0;
                  disp_nxt  = IDLE_VAL;
               end
            end else if (dwell_cnt == 32'd0 && |other_req) begin
               // Dwell served and someone else is waiting: rotate
               owner_nxt = pick_oth;
               last_nxt  = pick_oth;
               dwell_nxt = DWELL - 32'd1;
               disp_nxt  = val_of(bus.vals, pick_oth);
            end else begin
               disp_nxt = val_of(bus.vals, owner);
               if (dwell_cnt != 32'd0) dwell_nxt = dwell_cnt - 32'd1;
            end
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         owner     <= 3'd0;
         last      <= 3'(NREQ - 1);
         dwell_cnt <= 32'd0;
         disp_val  <= IDLE_VAL;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         dwell_cnt <= dwell_nxt;
         disp_val  <= disp_nxt;
      end
   end

   assign bus.disp_val  = disp_val;
   assign bus.grant     = (state == ST_HOLD) ? own_onehot : '0;
   assign bus.owner     = owner;
   assign bus.busy      = (state == ST_HOLD);
   assign bus.state_dbg = state[0];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with NREQ=4, DWELL=4.
module tb_display_arbiter;

   localparam int          NREQ     = 4;
   localparam logic [31:0] DWELL    = 32'd4;
   localparam logic [31:0] IDLE_VAL = 32'hEEEE_0000;
   localparam int          W        = 40;

   logic clk;
   logic resetn;
   int   errors;
   int   checks;
   logic [31:0]  src_val [NREQ];
   logic [W-1:0] exp_q [$];
   logic [W-1:0] exp_w;
   logic [W-1:0] act_w;

   display_arbiter_if #(.NREQ(NREQ)) bus ();

   display_arbiter #(
      .NREQ(NREQ),
      .DWELL(DWELL),
      .IDLE_VAL(IDLE_VAL)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vals();
      for (int i = 0; i < NREQ; i++) bus.vals[32*i +: 32] = src_val[i];
   endtask

   task automatic do_reset();
      resetn  = 1'b0;
      bus.req = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // Expected observation word: {busy, grant, owner, disp_val}
   function automatic logic [W-1:0] mk_exp(input int own, input logic hold, input logic [31:0] v);
      logic [NREQ-1:0] g;
      g = '0;
      if (hold) g[own] = 1'b1;
      return {hold, g, (hold ? 3'(own) : 3'd0), v};
   endfunction

   function automatic logic [W-1:0] observe();
      return {bus.busy, bus.grant, bus.owner, bus.disp_val};
   endfunction

   task automatic test_reset();
      resetn  = 1'b0;
      bus.req = 4'hF;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (observe() !== mk_exp(0, 1'b0, IDLE_VAL)) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h want %h", c, observe(), mk_exp(0, 1'b0, IDLE_VAL));
         end
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (observe() !== mk_exp(0, 1'b1, src_val[0])) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", observe(), mk_exp(0, 1'b1, src_val[0]));
      end
      bus.req = '0;
      tick();
      checks++;
      if (observe() !== mk_exp(0, 1'b0, IDLE_VAL)) begin
         errors++;
         $display("FAIL reset_to_idle: got %h want %h", observe(), mk_exp(0, 1'b0, IDLE_VAL));
      end
   endtask

   task automatic test_single();
      do_reset();
      src_val[2] = 32'h1234_5678;
      drive_vals();
      bus.req = 4'b0100;
      exp_q.push_back(mk_exp(2, 1'b1, 32'h1234_5678));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL single_grant: got %h want %h", act_w, exp_w);
      end
      src_val[2] = 32'h0000_CAFE;
      drive_vals();
      for (int c = 0; c < 10; c++) exp_q.push_back(mk_exp(2, 1'b1, 32'h0000_CAFE));
      while (exp_q.size() > 0) begin
         tick();
         exp_w = exp_q.pop_front();
         act_w = observe();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL single_hold: got %h want %h", act_w, exp_w);
         end
      end
      // Long-held owner has dwell at zero: a contender takes over on the next edge
      bus.req = 4'b0110;
      exp_q.push_back(mk_exp(1, 1'b1, src_val[1]));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL single_preempt: got %h want %h", act_w, exp_w);
      end
   endtask

   task automatic test_contention();
      do_reset();
      bus.req = 4'b0011;
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(0, 1'b1, src_val[0]));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(1, 1'b1, src_val[1]));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(0, 1'b1, src_val[0]));
      while (exp_q.size() > 0) begin
         tick();
         exp_w = exp_q.pop_front();
         act_w = observe();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL contention: got %h want %h", act_w, exp_w);
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      bus.req = 4'b1010;
      exp_q.push_back(mk_exp(1, 1'b1, src_val[1]));
      exp_q.push_back(mk_exp(1, 1'b1, src_val[1]));
      repeat (2) begin
         tick();
         exp_w = exp_q.pop_front();
         act_w = observe();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL early_hold: got %h want %h", act_w, exp_w);
         end
      end
      bus.req = 4'b1000;
      exp_q.push_back(mk_exp(3, 1'b1, src_val[3]));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL early_release: got %h want %h", act_w, exp_w);
      end
      bus.req = '0;
      exp_q.push_back(mk_exp(0, 1'b0, IDLE_VAL));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL early_idle: got %h want %h", act_w, exp_w);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.req = 4'b1001;
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(0, 1'b1, src_val[0]));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(3, 1'b1, src_val[3]));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk_exp(0, 1'b1, src_val[0]));
      while (exp_q.size() > 0) begin
         tick();
         exp_w = exp_q.pop_front();
         act_w = observe();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL wrap: got %h want %h", act_w, exp_w);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      bus.req = 4'b0001;
      for (int c = 0; c < 3; c++) exp_q.push_back(mk_exp(0, 1'b1, src_val[0]));
      while (exp_q.size() > 0) begin
         tick();
         exp_w = exp_q.pop_front();
         act_w = observe();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL midhold_pre: got %h want %h", act_w, exp_w);
         end
      end
      resetn = 1'b0;
      exp_q.push_back(mk_exp(0, 1'b0, IDLE_VAL));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL midhold_reset: got %h want %h", act_w, exp_w);
      end
      resetn  = 1'b1;
      bus.req = 4'b1000;
      exp_q.push_back(mk_exp(3, 1'b1, src_val[3]));
      tick();
      exp_w = exp_q.pop_front();
      act_w = observe();
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL midhold_release: got %h want %h", act_w, exp_w);
      end
   endtask

   // Test sequence and final report
   initial begin
      errors  = 0;
      checks  = 0;
      resetn  = 1'b0;
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) src_val[i] = $urandom_range(32'h7FFF_FFFF, 32'h1000_0000) | (32'(i) << 28);
      drive_vals();
      test_reset();
      test_single();
      test_contention();
      test_early_release();
      test_wrap();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
